// File: rtl/deserializer.sv
// Serial-to-parallel word assembler, LSB first, with a one-word holding register.
// Optional sticky drop flag enabled by defining DESERIALIZER_OVERRUN_EN.
module deserializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             I,
  input  logic             I_en,
  input  logic             sync,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready
`ifdef DESERIALIZER_OVERRUN_EN
  ,
  output logic             overrun,
  input  logic             overrun_clr
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Only the upper WIDTH-1 shift bits are ever read back.
  logic [WIDTH-2:0] sh;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             free;
  logic             drop;

  always_comb begin
    word = {I, sh};
    done = I_en && !sync && (cnt == LAST);
    free = !O_valid || O_ready;
    drop = done && !free;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh  <= '0;
      cnt <= '0;
    end else if (sync) begin
      cnt <= I_en ? CW'(1) : '0;
      if (I_en) sh <= word[WIDTH-1:1];
    end else if (I_en) begin
      sh  <= word[WIDTH-1:1];
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      O       <= '0;
      O_valid <= 1'b0;
    end else if (done && free) begin
      O       <= word;
      O_valid <= 1'b1;
    end else if (O_valid && O_ready) begin
      O_valid <= 1'b0;
    end
  end

`ifdef DESERIALIZER_OVERRUN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter WIDTH, default 32: word width in bits; the shift register width and output width; legal range WIDTH >= 2.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release is synchronous to clk.
REQ-004 I  input  1  serial data bit, LSB of each word first.
REQ-005 I_en  input  1  I carries a valid bit this cycle; the bit is ignored when low.
REQ-006 sync  input  1  frame restart; the bit count returns to bit 0 of a new word.
REQ-007 O  output  WIDTH  assembled parallel word.
REQ-008 O_valid  output  1  O holds an unconsumed word.
REQ-009 O_ready  input  1  consumer accepts O this cycle when O_valid is high.
REQ-010 overrun  output  1  sticky word-dropped flag; present only under DESERIALIZER_OVERRUN_EN.
REQ-011 overrun_clr  input  1  clears overrun; present only under DESERIALIZER_OVERRUN_EN.

Function
REQ-012 Internal state: shift register sh[WIDTH-1:0], bit counter cnt in the range 0..WIDTH-1, and the output holding register O/O_valid.
REQ-013 I_en=1, sync=0: sh <= {I, sh[WIDTH-1:1]} and cnt increments.
REQ-014 When a bit is taken with cnt==WIDTH-1, the word completes: the word is {I, sh[WIDTH-1:1]} and cnt wraps to 0.
REQ-015 I_en=0, sync=0: sh and cnt hold.
REQ-016 sync=1, I_en=0: cnt <= 0; partial bits are discarded and no word completes.
REQ-017 sync=1, I_en=1: I is taken as bit 0 of the new word and cnt <= 1.
REQ-018 sync=1, I_en=1, WIDTH>=2: no word completes, even when cnt was WIDTH-1.
REQ-019 Bit k of a word (k = 0..WIDTH-1, k-th accepted bit after the frame start) appears at O[k].
REQ-020 Latency: O and O_valid update at the same clk edge that samples the final bit; they are visible in the following cycle.
REQ-021 Handshake: a word transfers on any cycle with O_valid=1 and O_ready=1.
REQ-022 O stays stable while O_valid=1 and O_ready=0.
REQ-023 Completion while the holding register is free (O_valid=0, or O_valid=1 and O_ready=1): O <= word and O_valid <= 1, so back-to-back words incur no bubble.
REQ-024 Completion while the holding register is blocked (O_valid=1, O_ready=0): the new word is dropped and O/O_valid are unchanged.
REQ-025 O_valid=1, O_ready=1 with no completion: O_valid <= 0 and O retains its last value.
REQ-026 Continuous I_en=1 with sync=0 produces one completed word every WIDTH cycles.
REQ-027 Reset during a partial word discards the partial word; after reset release, the first accepted bit is bit 0.

Reset
REQ-028 While reset=0: sh=0, cnt=0, O=0, O_valid=0, and overrun=0 (when present).
REQ-029 Reset acts independently of clk and overrides every other input.

Configuration
REQ-030 Macro DESERIALIZER_OVERRUN_EN defined: overrun is set on the cycle after any drop per REQ-024.
REQ-031 With DESERIALIZER_OVERRUN_EN defined, overrun remains set until an overrun_clr=1 cycle clears it.
REQ-032 With DESERIALIZER_OVERRUN_EN defined, a drop and overrun_clr=1 in the same cycle leave overrun=1 (set wins).
REQ-033 Macro undefined: the overrun and overrun_clr ports and their logic are absent, and drops are silent; all other behaviour is identical.

Verification (WIDTH=8 unless noted)
REQ-034 Reset release, then I_en=1 with bits LSB-first of 0xA5 and O_ready=1 -> O=0xA5 and O_valid=1 for exactly one cycle, the cycle after the 8th bit.
REQ-035 Continuous stream 0x3C then 0xC3, I_en always 1, O_ready=1 -> O_valid pulses 8 cycles apart, with O=0x3C then O=0xC3.
REQ-036 Three bits of junk, then sync=1 with I_en=1 carrying bit 0 of 0x81, then the remaining 7 bits -> a single word O=0x81; no word is produced from the junk bits.
REQ-037 O_ready=0 while the words 0x11 and 0x22 complete -> O stays 0x11 and the 0x22 word is dropped; with the macro defined, overrun=1 until overrun_clr, and after overrun_clr overrun=0.
REQ-038 reset driven low mid-word at bit 4, with a word pending -> O_valid=0 and O=0 immediately, without waiting for a clock edge; the next 8 bits after release form a complete word.
REQ-039 WIDTH=32, random words over 1000 frames with random I_en gaps and O_ready stalls, compared against a scoreboard -> every accepted word matches and every drop coincides with a blocked holding register.
